mem_access_ctrl: RTL and testbench

MEM-stage data-memory access sequencer for the pipelined MIPS core. Accepts one load/store per instruction from the MEM stage, checks alignment, drives a request/acknowledge handshake toward the system bridge, stalls the pipeline until the bridge responds, and hands the raw read word plus byte offset and load-control code to the load-extension unit in WB. Stores are aligned here (byte enables, lane shifting), including swl/swr.

---
 rtl/mem_access_ctrl_pkg.sv | 29 ++
 rtl/mem_access_ctrl_if.sv | 49 ++++
 rtl/mem_access_ctrl_store_align.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage access sequencer: load/store width codes,
// FSM state encoding and the alignment rule.
package mem_access_ctrl_pkg;

    localparam logic [2:0] SL_WORD      = 3'd0;
    localparam logic [2:0] SL_HALF      = 3'd1;
    localparam logic [2:0] SL_BYTE      = 3'd2;
    localparam logic [2:0] SL_HALFU     = 3'd3;
    localparam logic [2:0] SL_BYTEU     = 3'd4;
    localparam logic [2:0] SL_WORDLEFT  = 3'd5;
    localparam logic [2:0] SL_WORDRIGHT = 3'd6;

    typedef enum logic [1:0] {
        MAS_IDLE  = 2'd0,
        MAS_REQ   = 2'd1,
        MAS_DONE  = 2'd2,
        MAS_DRAIN = 2'd3
    } mas_state_t;

    // Byte, swl/swr and lwl/lwr style accesses can never fault.
    function automatic logic is_aligned(input logic [1:0] a, input logic [2:0] ctrl);
        case (ctrl)
            SL_WORD:           return a == 2'b00;
            SL_HALF, SL_HALFU: return !a[0];
            default:           return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// MEM-stage / bridge signal bundle for mem_access_ctrl.
// bus_err_o exists only when MEM_TIMEOUT_EN is defined.
interface mem_access_ctrl_if;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] addr_i;
    logic [2:0]  sl_ctrl_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        adel_o;
    logic        ades_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        ld_valid_o;
    logic [31:0] ld_raw_o;
    logic [1:0]  ld_bytesel_o;
    logic [2:0]  ld_ctrl_o;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err_o;
`endif

    // master: the sequencer itself; slave: pipeline + bridge environment
    modport master (
        input  mem_req_i, mem_we_i, addr_i, sl_ctrl_i, wdata_i, flush_i,
        input  bus_ack_i, bus_rdata_i,
        output stall_o, adel_o, ades_o, bus_req_o, bus_we_o, bus_addr_o,
        output bus_be_o, bus_wdata_o, ld_valid_o, ld_raw_o, ld_bytesel_o, ld_ctrl_o
`ifdef MEM_TIMEOUT_EN
        , output bus_err_o
`endif
    );

    modport slave (
        output mem_req_i, mem_we_i, addr_i, sl_ctrl_i, wdata_i, flush_i,
        output bus_ack_i, bus_rdata_i,
        input  stall_o, adel_o, ades_o, bus_req_o, bus_we_o, bus_addr_o,
        input  bus_be_o, bus_wdata_o, ld_valid_o, ld_raw_o, ld_bytesel_o, ld_ctrl_o
`ifdef MEM_TIMEOUT_EN
        , input bus_err_o
`endif
    );

endinterface

// File: rtl/mem_access_ctrl_store_align.sv
// Combinational store lane steering: byte enables and shifted data for
// sw/sh/sb/swl/swr on a little-endian 32-bit bus.
module store_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  a,
    input  logic [2:0]  ctrl,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] data
);

    always_comb begin
        be   = 4'b0000;
        data = wdata;
        case (ctrl)
            SL_WORD: begin
                be   = 4'b1111;
                data = wdata;
            end
            SL_HALF, SL_HALFU: begin
                be   = 4'b0011 << {a[1], 1'b0};
                data = wdata << {a[1], 4'b0000};
            end
            SL_BYTE, SL_BYTEU: begin
                be   = 4'b0001 << a;
                data = wdata << {a, 3'b000};
            end
            // swl writes the upper bytes of the register into the low lanes
            SL_WORDLEFT: begin
                be   = 4'b1111 >> (2'd3 - a);
                data = wdata >> {~a, 3'b000};
            end
            SL_WORDRIGHT: begin
                be   = 4'b1111 << a;
                data = wdata << {a, 3'b000};
            end
            default: begin
                be   = 4'b0000;
                data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: alignment check, req/ack toward the
// bridge, pipeline stall, load hand-off to WB. Optional: MEM_TIMEOUT_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic              clk,
    input  logic              reset_n,
    mem_access_ctrl_if.master mac
);

    mas_state_t  state;
    logic [1:0]  a_q;
    logic [2:0]  ctrl_q;
    logic        aligned;
    logic        accept;
    logic        tmo;
    logic [3:0]  st_be;
    logic [31:0] st_data;

    store_align u_align (
        .a     (mac.addr_i[1:0]),
        .ctrl  (mac.sl_ctrl_i),
        .wdata (mac.wdata_i),
        .be    (st_be),
        .data  (st_data)
    );

    assign aligned     = is_aligned(mac.addr_i[1:0], mac.sl_ctrl_i);
    assign accept      = (state == MAS_IDLE) && mac.mem_req_i && aligned && !mac.flush_i;
    assign mac.stall_o = accept || (state == MAS_REQ) || (state == MAS_DRAIN);
    assign mac.adel_o  = mac.mem_req_i && !mac.mem_we_i && !aligned;
    assign mac.ades_o  = mac.mem_req_i &&  mac.mem_we_i && !aligned;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt;
    // cnt holds the number of REQ/DRAIN cycles already spent
    assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= MAS_IDLE;
            a_q              <= '0;
            ctrl_q           <= '0;
            mac.bus_req_o    <= 1'b0;
            mac.bus_we_o     <= 1'b0;
            mac.bus_addr_o   <= '0;
            mac.bus_be_o     <= '0;
            mac.bus_wdata_o  <= '0;
            mac.ld_valid_o   <= 1'b0;
            mac.ld_raw_o     <= '0;
            mac.ld_bytesel_o <= '0;
            mac.ld_ctrl_o    <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt              <= '0;
            mac.bus_err_o    <= 1'b0;
`endif
        end else begin
            mac.ld_valid_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mac.bus_err_o  <= 1'b0;
`endif
            case (state)
                MAS_IDLE: begin
                    if (accept) begin
                        state           <= MAS_REQ;
                        mac.bus_req_o   <= 1'b1;
                        mac.bus_we_o    <= mac.mem_we_i;
                        mac.bus_addr_o  <= {mac.addr_i[31:2], 2'b00};
                        mac.bus_be_o    <= mac.mem_we_i ? st_be : 4'b0000;
                        mac.bus_wdata_o <= mac.mem_we_i ? st_data : 32'h0;
                        a_q             <= mac.addr_i[1:0];
                        ctrl_q          <= mac.sl_ctrl_i;
`ifdef MEM_TIMEOUT_EN
                        cnt             <= '0;
`endif
                    end
                end
                MAS_REQ, MAS_DRAIN: begin
                    if (mac.bus_ack_i) begin
                        mac.bus_req_o <= 1'b0;
                        // a flush seen with or before the ack discards the data
                        if (state == MAS_REQ && !mac.flush_i) begin
                            state <= MAS_DONE;
                            if (!mac.bus_we_o) begin
                                mac.ld_valid_o   <= 1'b1;
                                mac.ld_raw_o     <= mac.bus_rdata_i;
                                mac.ld_bytesel_o <= a_q;
                                mac.ld_ctrl_o    <= ctrl_q;
                            end
                        end else begin
                            state <= MAS_IDLE;
                        end
                    end else if (tmo) begin
                        mac.bus_req_o <= 1'b0;
                        state         <= MAS_DONE;
`ifdef MEM_TIMEOUT_EN
                        mac.bus_err_o <= 1'b1;
`endif
                    end else if (mac.flush_i) begin
                        state <= MAS_DRAIN;
                    end
`ifdef MEM_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
`endif
                end
                MAS_DONE: state <= MAS_IDLE;
                default:  state <= MAS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the timeout case runs
// only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic clk;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;

    // results of the most recent access() call
    int          st_cnt, req_cnt, vld_req;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    mem_access_ctrl_if mac ();

`ifdef MEM_TIMEOUT_EN
    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .reset_n(reset_n), .mac(mac));
`else
    mem_access_ctrl dut (.clk(clk), .reset_n(reset_n), .mac(mac));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access, ack it after 'waits' extra REQ cycles, return in the DONE cycle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] ctrl,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits);
        st_cnt = 0; req_cnt = 0; vld_req = 0;
        tick();
        mac.mem_req_i = 1'b1; mac.mem_we_i = we; mac.addr_i = addr;
        mac.sl_ctrl_i = ctrl; mac.wdata_i = wd;
        #1;
        st_cnt += int'(mac.stall_o);
        for (int c = 0; c <= waits; c++) begin
            tick();
            mac.bus_ack_i   = (c == waits);
            mac.bus_rdata_i = (c == waits) ? rd : 32'h0BAD_F00D;
            #1;
            st_cnt  += int'(mac.stall_o);
            req_cnt += int'(mac.bus_req_o);
            vld_req += int'(mac.ld_valid_o);
            if (c == waits) begin
                cap_addr = mac.bus_addr_o; cap_be = mac.bus_be_o;
                cap_wdata = mac.bus_wdata_o; cap_we = mac.bus_we_o;
            end
        end
        tick();
        mac.bus_ack_i = 1'b0; mac.mem_req_i = 1'b0;
        #1;
        st_cnt += int'(mac.stall_o);
    endtask

    initial begin
        mac.mem_req_i = 0; mac.mem_we_i = 0; mac.addr_i = 0; mac.sl_ctrl_i = 0;
        mac.wdata_i = 0; mac.flush_i = 0; mac.bus_ack_i = 0; mac.bus_rdata_i = 0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst bus_req", 32'(mac.bus_req_o), 32'd0);
        chk("rst ld_valid", 32'(mac.ld_valid_o), 32'd0);
        chk("rst bus_be", 32'(mac.bus_be_o), 32'd0);
        chk("rst ld_raw", mac.ld_raw_o, 32'd0);
        chk("rst stall", 32'(mac.stall_o), 32'd0);
`ifdef MEM_TIMEOUT_EN
        chk("rst bus_err", 32'(mac.bus_err_o), 32'd0);
`endif
        reset_n = 1'b1;

        // lw 0x100, three wait cycles
        access(1'b0, 32'h100, SL_WORD, 32'h0, 32'hDEADBEEF, 3);
        chk("lw stall cycles", st_cnt, 32'd5);
        chk("lw req cycles", req_cnt, 32'd4);
        chk("lw early vld", vld_req, 32'd0);
        chk("lw bus_addr", cap_addr, 32'h100);
        chk("lw bus_be", 32'(cap_be), 32'h0);
        chk("lw bus_we", 32'(cap_we), 32'd0);
        chk("lw ld_valid", 32'(mac.ld_valid_o), 32'd1);
        chk("lw ld_raw", mac.ld_raw_o, 32'hDEADBEEF);
        chk("lw bytesel", 32'(mac.ld_bytesel_o), 32'd0);
        chk("lw done req", 32'(mac.bus_req_o), 32'd0);
        tick();
        chk("lw vld pulse", 32'(mac.ld_valid_o), 32'd0);
        chk("lw raw held", mac.ld_raw_o, 32'hDEADBEEF);

        // sb 0x203, immediate ack
        access(1'b1, 32'h203, SL_BYTE, 32'h000000A5, 32'h0, 0);
        chk("sb stall cycles", st_cnt, 32'd2);
        chk("sb bus_be", 32'(cap_be), 32'b1000);
        chk("sb bus_wdata", cap_wdata, 32'hA5000000);
        chk("sb bus_addr", cap_addr, 32'h200);
        chk("sb bus_we", 32'(cap_we), 32'd1);
        chk("sb no vld", 32'(mac.ld_valid_o), 32'd0);
        chk("sb raw held", mac.ld_raw_o, 32'hDEADBEEF);

        // swl / swr 0x301
        access(1'b1, 32'h301, SL_WORDLEFT, 32'h11223344, 32'h0, 1);
        chk("swl bus_be", 32'(cap_be), 32'b0011);
        chk("swl bus_wdata", cap_wdata, 32'h00001122);
        chk("swl stall cycles", st_cnt, 32'd3);
        access(1'b1, 32'h301, SL_WORDRIGHT, 32'h11223344, 32'h0, 0);
        chk("swr bus_be", 32'(cap_be), 32'b1110);
        chk("swr bus_wdata", cap_wdata, 32'h22334400);

        // sh to the upper half, sw full word
        access(1'b1, 32'h102, SL_HALF, 32'h11223344, 32'h0, 0);
        chk("sh bus_be", 32'(cap_be), 32'b1100);
        chk("sh bus_wdata", cap_wdata, 32'h33440000);
        chk("sh bus_addr", cap_addr, 32'h100);
        access(1'b1, 32'h404, SL_WORD, 32'hCAFEF00D, 32'h0, 0);
        chk("sw bus_be", 32'(cap_be), 32'b1111);
        chk("sw bus_wdata", cap_wdata, 32'hCAFEF00D);

        // lbu 0x203: byte offset and code forwarded to WB
        access(1'b0, 32'h203, SL_BYTEU, 32'h0, 32'h12345678, 2);
        chk("lbu ld_raw", mac.ld_raw_o, 32'h12345678);
        chk("lbu bytesel", 32'(mac.ld_bytesel_o), 32'd3);
        chk("lbu ld_ctrl", 32'(mac.ld_ctrl_o), 32'(SL_BYTEU));
        chk("lbu ld_valid", 32'(mac.ld_valid_o), 32'd1);

        // misaligned lh / sw: fault, no request, no stall
        tick();
        mac.mem_req_i = 1; mac.mem_we_i = 0; mac.addr_i = 32'h101; mac.sl_ctrl_i = SL_HALF;
        #1;
        chk("lh adel", 32'(mac.adel_o), 32'd1);
        chk("lh ades", 32'(mac.ades_o), 32'd0);
        chk("lh stall", 32'(mac.stall_o), 32'd0);
        tick();
        chk("lh no req", 32'(mac.bus_req_o), 32'd0);
        mac.mem_we_i = 1; mac.addr_i = 32'h102; mac.sl_ctrl_i = SL_WORD;
        #1;
        chk("sw ades", 32'(mac.ades_o), 32'd1);
        chk("sw adel", 32'(mac.adel_o), 32'd0);
        mac.sl_ctrl_i = SL_WORDLEFT; mac.addr_i = 32'h103;
        #1;
        chk("swl no fault", 32'(mac.ades_o), 32'd0);
        mac.mem_req_i = 0;

        // flush together with request in IDLE
        tick();
        mac.mem_req_i = 1; mac.mem_we_i = 0; mac.addr_i = 32'h500; mac.sl_ctrl_i = SL_WORD;
        mac.flush_i = 1;
        #1;
        chk("idle flush stall", 32'(mac.stall_o), 32'd0);
        tick();
        mac.mem_req_i = 0; mac.flush_i = 0;
        chk("idle flush no req", 32'(mac.bus_req_o), 32'd0);

        // ack while idle is ignored
        mac.bus_ack_i = 1; mac.bus_rdata_i = 32'h55555555;
        tick();
        mac.bus_ack_i = 0;
        chk("idle ack vld", 32'(mac.ld_valid_o), 32'd0);
        chk("idle ack raw", mac.ld_raw_o, 32'h12345678);

        // flush in first REQ cycle, ack two cycles later -> DRAIN
        mac.mem_req_i = 1; mac.mem_we_i = 0; mac.addr_i = 32'h600; mac.sl_ctrl_i = SL_WORD;
        tick();
        mac.flush_i = 1;
        #1;
        chk("drain req c1", 32'(mac.stall_o), 32'd1);
        tick();
        mac.flush_i = 0; mac.mem_req_i = 0;
        #1;
        chk("drain stall", 32'(mac.stall_o), 32'd1);
        chk("drain req up", 32'(mac.bus_req_o), 32'd1);
        tick();
        mac.bus_ack_i = 1; mac.bus_rdata_i = 32'h99999999;
        #1;
        chk("drain stall ack", 32'(mac.stall_o), 32'd1);
        tick();
        mac.bus_ack_i = 0;
        chk("drain idle req", 32'(mac.bus_req_o), 32'd0);
        chk("drain idle stall", 32'(mac.stall_o), 32'd0);
        chk("drain no vld", 32'(mac.ld_valid_o), 32'd0);
        chk("drain raw kept", mac.ld_raw_o, 32'h12345678);

        // flush and ack in the same REQ cycle
        mac.mem_req_i = 1; mac.addr_i = 32'h700;
        tick();
        mac.mem_req_i = 0; mac.flush_i = 1; mac.bus_ack_i = 1; mac.bus_rdata_i = 32'h77777777;
        tick();
        mac.flush_i = 0; mac.bus_ack_i = 0;
        chk("fa no vld", 32'(mac.ld_valid_o), 32'd0);
        chk("fa stall", 32'(mac.stall_o), 32'd0);
        chk("fa raw kept", mac.ld_raw_o, 32'h12345678);

        // reset asserted mid-REQ
        mac.mem_req_i = 1; mac.addr_i = 32'h800;
        tick();
        chk("rst mid req up", 32'(mac.bus_req_o), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst mid req drop", 32'(mac.bus_req_o), 32'd0);
        chk("rst mid addr", mac.bus_addr_o, 32'd0);
        mac.mem_req_i = 0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst mid idle", 32'(mac.stall_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // no ack: abort after 4 REQ cycles
        mac.mem_req_i = 1; mac.mem_we_i = 0; mac.addr_i = 32'h900; mac.sl_ctrl_i = SL_WORD;
        tick();
        mac.mem_req_i = 0;
        for (int c = 0; c < 4; c++) begin
            chk("tmo req up", 32'(mac.bus_req_o), 32'd1);
            tick();
        end
        chk("tmo req drop", 32'(mac.bus_req_o), 32'd0);
        chk("tmo bus_err", 32'(mac.bus_err_o), 32'd1);
        chk("tmo stall", 32'(mac.stall_o), 32'd0);
        chk("tmo no vld", 32'(mac.ld_valid_o), 32'd0);
        tick();
        chk("tmo err pulse", 32'(mac.bus_err_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
